// File: rtl/footsies_pkg.sv
// Shared Footsies types and defaults: stun kinds, coordinate width, stun lengths, character states.
package footsies_pkg;

   typedef enum logic [1:0] {
      STUN_NONE  = 2'd0,
      STUN_HIT   = 2'd1,
      STUN_BLOCK = 2'd2
   } stun_e;

   localparam int COORD_W              = 10;
   localparam int HITSTUN_FRAMES_DEF   = 18;
   localparam int BLOCKSTUN_FRAMES_DEF = 12;

   // Character FSM states, same encoding the sprite box tables index by
   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_WALK_FWD  = 4'd1;
   localparam logic [3:0] ST_WALK_BACK = 4'd2;
   localparam logic [3:0] ST_ATTACK    = 4'd3;
   localparam logic [3:0] ST_HITSTUN   = 4'd4;
   localparam logic [3:0] ST_BLOCKSTUN = 4'd5;

endpackage

// File: rtl/box_overlap.sv
// Combinational AABB test: strict unsigned compares, so edge-touching boxes do not overlap.
module box_overlap #(
   parameter int W = 10
) (
   input  logic [W-1:0] a_x1_i,
   input  logic [W-1:0] a_x2_i,
   input  logic [W-1:0] a_y1_i,
   input  logic [W-1:0] a_y2_i,
   input  logic [W-1:0] b_x1_i,
   input  logic [W-1:0] b_x2_i,
   input  logic [W-1:0] b_y1_i,
   input  logic [W-1:0] b_y2_i,
   output logic         overlap_o
);

   assign overlap_o = (a_x1_i < b_x2_i) && (b_x1_i < a_x2_i) &&
                      (a_y1_i < b_y2_i) && (b_y1_i < a_y2_i);

endmodule

// File: rtl/hit_resolver.sv
// Per-frame hit/block resolution with single-hit latches and stun countdowns; one-cycle event pulses.
// Optional per-player hit score behind HIT_RESOLVER_SCORE_EN (otherwise scores read 0).
module hit_resolver #(
   parameter int COORD_W          = footsies_pkg::COORD_W,
   parameter int STUN_W           = 6,
   parameter int HITSTUN_FRAMES   = footsies_pkg::HITSTUN_FRAMES_DEF,
   parameter int BLOCKSTUN_FRAMES = footsies_pkg::BLOCKSTUN_FRAMES_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_tick,
   input  logic [COORD_W-1:0] p1_hit_x1,
   input  logic [COORD_W-1:0] p1_hit_x2,
   input  logic [COORD_W-1:0] p1_hit_y1,
   input  logic [COORD_W-1:0] p1_hit_y2,
   input  logic               p1_hit_active,
   input  logic [COORD_W-1:0] p1_hurt_x1,
   input  logic [COORD_W-1:0] p1_hurt_x2,
   input  logic [COORD_W-1:0] p1_hurt_y1,
   input  logic [COORD_W-1:0] p1_hurt_y2,
   input  logic               p1_hurt_active,
   input  logic               p1_block_req,
   input  logic [COORD_W-1:0] p2_hit_x1,
   input  logic [COORD_W-1:0] p2_hit_x2,
   input  logic [COORD_W-1:0] p2_hit_y1,
   input  logic [COORD_W-1:0] p2_hit_y2,
   input  logic               p2_hit_active,
   input  logic [COORD_W-1:0] p2_hurt_x1,
   input  logic [COORD_W-1:0] p2_hurt_x2,
   input  logic [COORD_W-1:0] p2_hurt_y1,
   input  logic [COORD_W-1:0] p2_hurt_y2,
   input  logic               p2_hurt_active,
   input  logic               p2_block_req,
   output logic               p1_got_hit,
   output logic               p1_got_blocked,
   output logic [1:0]         p1_stun,
   output logic [STUN_W-1:0]  p1_stun_left,
   output logic [3:0]         p1_score,
   output logic               p2_got_hit,
   output logic               p2_got_blocked,
   output logic [1:0]         p2_stun,
   output logic [STUN_W-1:0]  p2_stun_left,
   output logic [3:0]         p2_score
);
   import footsies_pkg::*;

   localparam logic [STUN_W-1:0] HIT_LOAD = STUN_W'(HITSTUN_FRAMES);
   localparam logic [STUN_W-1:0] BLK_LOAD = STUN_W'(BLOCKSTUN_FRAMES);
   localparam logic [STUN_W-1:0] ONE      = STUN_W'(1);

   logic [1:0] ovl;
   box_overlap #(.W(COORD_W)) u_ovl_p1 (
      .a_x1_i(p1_hit_x1),  .a_x2_i(p1_hit_x2),  .a_y1_i(p1_hit_y1),  .a_y2_i(p1_hit_y2),
      .b_x1_i(p2_hurt_x1), .b_x2_i(p2_hurt_x2), .b_y1_i(p2_hurt_y1), .b_y2_i(p2_hurt_y2),
      .overlap_o(ovl[0])
   );
   box_overlap #(.W(COORD_W)) u_ovl_p2 (
      .a_x1_i(p2_hit_x1),  .a_x2_i(p2_hit_x2),  .a_y1_i(p2_hit_y1),  .a_y2_i(p2_hit_y2),
      .b_x1_i(p1_hurt_x1), .b_x2_i(p1_hurt_x2), .b_y1_i(p1_hurt_y1), .b_y2_i(p1_hurt_y2),
      .overlap_o(ovl[1])
   );

   logic [1:0]        latch_q, got_hit_q, got_blk_q;
   stun_e             stun_q [2];
   logic [STUN_W-1:0] left_q [2];

   // Index 0 = player 1, 1 = player 2. contact[] is by attacker, the rest by defender.
   logic [1:0] hit_act, hurt_act, blk_req;
   logic [1:0] contact, contact_in, blocks, clean;
   assign hit_act  = {p2_hit_active, p1_hit_active};
   assign hurt_act = {p2_hurt_active, p1_hurt_active};
   assign blk_req  = {p2_block_req, p1_block_req};

   always_comb begin
      contact[0] = hit_act[0] && hurt_act[1] && ovl[0] && !latch_q[0];
      contact[1] = hit_act[1] && hurt_act[0] && ovl[1] && !latch_q[1];
      contact_in = {contact[0], contact[1]};
      blocks[0]  = blk_req[0] && (stun_q[0] != STUN_HIT);
      blocks[1]  = blk_req[1] && (stun_q[1] != STUN_HIT);
      clean      = contact_in & ~blocks;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         latch_q   <= '0;
         got_hit_q <= '0;
         got_blk_q <= '0;
         for (int d = 0; d < 2; d++) begin
            stun_q[d] <= STUN_NONE;
            left_q[d] <= '0;
         end
      end else begin
         got_hit_q <= '0;
         got_blk_q <= '0;
         for (int i = 0; i < 2; i++) begin
            if (!hit_act[i]) latch_q[i] <= 1'b0;
            if (frame_tick && contact[i]) latch_q[i] <= 1'b1;
         end
         if (frame_tick) begin
            for (int d = 0; d < 2; d++) begin
               if (contact_in[d] && blocks[d]) begin
                  got_blk_q[d] <= 1'b1;
                  stun_q[d]    <= STUN_BLOCK;
                  left_q[d]    <= BLK_LOAD;
               end else if (contact_in[d]) begin
                  got_hit_q[d] <= 1'b1;
                  stun_q[d]    <= STUN_HIT;
                  left_q[d]    <= HIT_LOAD;
               end else if (left_q[d] != '0) begin
                  left_q[d] <= left_q[d] - ONE;
                  if (left_q[d] == ONE) stun_q[d] <= STUN_NONE;
               end
            end
         end
      end
   end

   assign p1_got_hit     = got_hit_q[0];
   assign p1_got_blocked = got_blk_q[0];
   assign p1_stun        = stun_q[0];
   assign p1_stun_left   = left_q[0];
   assign p2_got_hit     = got_hit_q[1];
   assign p2_got_blocked = got_blk_q[1];
   assign p2_stun        = stun_q[1];
   assign p2_stun_left   = left_q[1];

`ifdef HIT_RESOLVER_SCORE_EN
   logic [3:0] score_q [2];
   // Attacker i scores when defender 1-i takes a clean hit; saturates at 15
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         score_q[0] <= '0;
         score_q[1] <= '0;
      end else if (frame_tick) begin
         if (clean[1] && score_q[0] != 4'hF) score_q[0] <= score_q[0] + 4'd1;
         if (clean[0] && score_q[1] != 4'hF) score_q[1] <= score_q[1] + 4'd1;
      end
   end
   assign p1_score = score_q[0];
   assign p2_score = score_q[1];
`else
   assign p1_score = 4'd0;
   assign p2_score = 4'd0;
`endif

endmodule
